spi_regfile_peripheral: RTL and testbench

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

---
 rtl/spi_regfile_peripheral_if.sv | 11 +
 rtl/spi_regfile_peripheral.sv | 199 +++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle shared by the controller (master) and the register-file peripheral (slave).
interface spi_regfile_peripheral_if;
    logic SCLK;
    logic nCS;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (output SCLK, output nCS, output COPI, input CIPO, input cipo_oe);
    modport slave  (input SCLK, input nCS, input COPI, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: 16-bit frames {R/W, addr[6:0], data[7:0]} write NUM_REGS registers.
// Define SPI_REGFILE_READBACK_EN to compile in the read path that returns register data on CIPO.
module spi_regfile_peripheral #(
    parameter int                NUM_REGS    = 8,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_regfile_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    logic [1:0]             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [15:0]            shreg_q, shreg_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
    logic                   frame_err_q, frame_err_d;

    // Sync chains reset low so a pin already low at reset release never looks like an nCS fall.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi.nCS};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.COPI};
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s      = copi_sync_q[SYNC_STAGES-1];
    assign sclk_prev_d = sclk_s;
    assign ncs_prev_d  = ncs_s;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign ncs_rise    = ncs_s & ~ncs_prev_q;
    assign ncs_fall    = ~ncs_s & ncs_prev_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[14:0], copi_s};
                    // Saturate so very long frames can never wrap back to a count of 16.
                    if (cnt_q != 5'd31) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cnt_q != 5'd16) begin
                    frame_err_d = 1'b1;
                end else if (shreg_q[15]) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (shreg_q[14:8] == 7'(k)) begin
                            regs_d[k]      = shreg_q[DATA_W-1:0];
                            wr_strobe_d[k] = 1'b1;
                        end
                    end
                end
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '0;
            copi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            copi_sync_q <= copi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
        assign regs_out[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

`ifdef SPI_REGFILE_READBACK_EN
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;
    logic [7:0] tx_q, tx_d;
    logic       rd_active_q, rd_active_d;
    logic       cipo_q, cipo_d;
    logic       cipo_oe_q, cipo_oe_d;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // Address as it will stand once the 8th header bit is shifted in.
    assign rd_addr   = {shreg_q[5:0], copi_s};

    always_comb begin
        rd_val = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == 7'(k)) begin
                rd_val = 8'(regs_q[k]);
            end
        end
    end

    always_comb begin
        tx_d        = tx_q;
        rd_active_d = rd_active_q;
        if (state_q == ST_SHIFT && !ncs_rise) begin
            if (sclk_rise && cnt_q == 5'd7 && !shreg_q[6]) begin
                tx_d        = rd_val;
                rd_active_d = 1'b1;
            end else if (sclk_fall && rd_active_q && cnt_q >= 5'd9) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
        if (state_q != ST_SHIFT || state_d != ST_SHIFT) begin
            tx_d        = '0;
            rd_active_d = 1'b0;
        end
        cipo_d    = rd_active_d & tx_d[7];
        cipo_oe_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q        <= '0;
            rd_active_q <= 1'b0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
        end else begin
            tx_q        <= tx_d;
            rd_active_q <= rd_active_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
        end
    end

    assign spi.CIPO    = cipo_q;
    assign spi.cipo_oe = cipo_oe_q;
`else
    assign spi.CIPO    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Randomized self-checking bench: an 8x8 and a 4x4 register file share one SPI bus,
// each compared against a per-frame behavioural model of the register contents.
module tb_spi_regfile_peripheral;
    localparam int         SYNC = 2;
    localparam int         HALF = 6;
    localparam logic [7:0] RV8  = 8'h3C;
    localparam logic [3:0] RV4  = 4'h9;

    logic        clk = 1'b0;
    logic        rst, sclk, ncs, copi;
    logic [63:0] regs8;
    logic [7:0]  st8;
    logic        err8;
    logic [15:0] regs4;
    logic [3:0]  st4;
    logic        err4;

    spi_regfile_peripheral_if bus8 ();
    spi_regfile_peripheral_if bus4 ();

    assign bus8.SCLK = sclk;
    assign bus8.nCS  = ncs;
    assign bus8.COPI = copi;
    assign bus4.SCLK = sclk;
    assign bus4.nCS  = ncs;
    assign bus4.COPI = copi;

    spi_regfile_peripheral #(.NUM_REGS(8), .DATA_W(8), .RESET_VAL(RV8), .SYNC_STAGES(SYNC)) u_dut8 (
        .clk(clk), .rst(rst), .spi(bus8), .regs_out(regs8), .wr_strobe(st8), .frame_err(err8));

    spi_regfile_peripheral #(.NUM_REGS(4), .DATA_W(4), .RESET_VAL(RV4), .SYNC_STAGES(SYNC)) u_dut4 (
        .clk(clk), .rst(rst), .spi(bus4), .regs_out(regs4), .wr_strobe(st4), .frame_err(err4));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pulses8, pulses4, errs8, errs4;
    logic [7:0]  st_or8;
    logic [3:0]  st_or4;
    logic [63:0] regs_at_st8;
    logic [15:0] regs_at_st4;
    logic [7:0]  model8 [8];
    logic [3:0]  model4 [4];

    always @(negedge clk) begin
        if (st8 != 8'h00) begin
            pulses8++;
            st_or8 |= st8;
            regs_at_st8 = regs8;
        end
        if (st4 != 4'h0) begin
            pulses4++;
            st_or4 |= st4;
            regs_at_st4 = regs4;
        end
        if (err8) errs8++;
        if (err4) errs4++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic clr_mon();
        pulses8 = 0; pulses4 = 0; errs8 = 0; errs4 = 0;
        st_or8 = '0; st_or4 = '0; regs_at_st8 = '0; regs_at_st4 = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) model8[k] = RV8;
        for (int k = 0; k < 4; k++) model4[k] = RV4;
    endtask

    function automatic logic [63:0] flat8();
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[k*8 +: 8] = model8[k];
        return f;
    endfunction

    function automatic logic [15:0] flat4();
        logic [15:0] f;
        for (int k = 0; k < 4; k++) f[k*4 +: 4] = model4[k];
        return f;
    endfunction

    task automatic sclk_bit(input logic b, output logic c8, output logic c4);
        copi = b;
        step(HALF);
        c8 = bus8.CIPO;
        c4 = bus4.CIPO;
        sclk = 1'b1;
        step(HALF);
        sclk = 1'b0;
    endtask

    // Sends nbits of 'bits' MSB first, then checks both DUTs against the model.
    task automatic run_frame(input logic [31:0] bits, input int nbits, input string tag);
        logic [15:0] hdr;
        logic [6:0]  addr;
        logic [7:0]  exp_st8, rd8, rd4, exp_rd8, exp_rd4;
        logic [3:0]  exp_st4;
        logic        c8, c4, oe8_mid, oe4_mid;
        int          exp_err;
        hdr     = bits[15:0];
        addr    = hdr[14:8];
        exp_st8 = '0;
        exp_st4 = '0;
        exp_err = (nbits != 16) ? 1 : 0;
        exp_rd8 = (addr < 7'd8) ? model8[addr[2:0]] : 8'h00;
        exp_rd4 = (addr < 7'd4) ? {4'h0, model4[addr[1:0]]} : 8'h00;
        if (nbits == 16 && hdr[15]) begin
            if (addr < 7'd8) begin
                model8[addr[2:0]]  = hdr[7:0];
                exp_st8[addr[2:0]] = 1'b1;
            end
            if (addr < 7'd4) begin
                model4[addr[1:0]]  = hdr[3:0];
                exp_st4[addr[1:0]] = 1'b1;
            end
        end
        rd8 = '0;
        rd4 = '0;
        clr_mon();
        ncs = 1'b0;
        step(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(bits[nbits-1-i], c8, c4);
            if (i >= 8 && i < 16) begin
                rd8 = {rd8[6:0], c8};
                rd4 = {rd4[6:0], c4};
            end
        end
        step(HALF);
        oe8_mid = bus8.cipo_oe;
        oe4_mid = bus4.cipo_oe;
        ncs  = 1'b1;
        copi = 1'b0;
        step(SYNC + 2);
        check({tag, " regs8@lat"}, regs8, flat8());
        check({tag, " regs4@lat"}, 64'(regs4), 64'(flat4()));
        step(4);
        check({tag, " strobe8"}, 64'(st_or8), 64'(exp_st8));
        check({tag, " strobe8_cnt"}, 64'(pulses8), (exp_st8 != 0) ? 64'd1 : 64'd0);
        check({tag, " strobe4"}, 64'(st_or4), 64'(exp_st4));
        check({tag, " frame_err8"}, 64'(errs8), 64'(exp_err));
        check({tag, " frame_err4"}, 64'(errs4), 64'(exp_err));
        if (exp_st8 != 0) check({tag, " regs8@strobe"}, regs_at_st8, flat8());
        if (exp_st4 != 0) check({tag, " regs4@strobe"}, 64'(regs_at_st4), 64'(flat4()));
        check({tag, " cipo_idle"}, 64'({bus8.CIPO, bus4.CIPO, bus8.cipo_oe, bus4.cipo_oe}), 64'd0);
`ifdef SPI_REGFILE_READBACK_EN
        check({tag, " oe_active"}, 64'({oe8_mid, oe4_mid}), 64'd3);
        if (nbits == 16 && !hdr[15]) begin
            check({tag, " read8"}, 64'(rd8), 64'(exp_rd8));
            check({tag, " read4"}, 64'(rd4), 64'(exp_rd4));
        end
`else
        check({tag, " oe_off"}, 64'({oe8_mid, oe4_mid}), 64'd0);
        if (nbits == 16) check({tag, " cipo_off"}, 64'({rd8, rd4}), 64'd0);
`endif
    endtask

    task automatic reset_mid_frame();
        logic [15:0] f;
        logic        c8, c4;
        f = 16'h8177;
        clr_mon();
        ncs = 1'b0;
        step(HALF);
        for (int i = 0; i < 8; i++) sclk_bit(f[15-i], c8, c4);
        rst = 1'b1;
        step(2);
        model_reset();
        check("rst_mid regs8 in reset", regs8, flat8());
        rst = 1'b0;
        for (int i = 8; i < 16; i++) sclk_bit(f[15-i], c8, c4);
        step(HALF);
        ncs = 1'b1;
        step(SYNC + 6);
        check("rst_mid regs8", regs8, flat8());
        check("rst_mid regs4", 64'(regs4), 64'(flat4()));
        check("rst_mid strobes", 64'(pulses8 + pulses4), 64'd0);
        check("rst_mid frame_err", 64'(errs8 + errs4), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bits;
        int          nbits, kind;
        rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
        clr_mon();
        model_reset();
        step(4);
        check("reset regs8", regs8, flat8());
        check("reset regs4", 64'(regs4), 64'(flat4()));
        check("reset outs", 64'({st8, st4, err8, err4}), 64'd0);
        rst = 1'b0;
        step(10);
        check("post_reset regs8", regs8, flat8());
        check("post_reset pulses", 64'(pulses8 + pulses4 + errs8 + errs4), 64'd0);
        check("post_reset cipo", 64'({bus8.CIPO, bus8.cipo_oe, bus4.CIPO, bus4.cipo_oe}), 64'd0);

        run_frame(32'h8255, 16, "w8255");
        check("w8255 reg2", 64'(regs8[23:16]), 64'h55);
        run_frame(32'h0ABC, 12, "short12");
        run_frame(32'h1_8255, 17, "long17");
        run_frame(32'h8A33, 16, "bad_addr10");
        run_frame(32'h83A5, 16, "w83A5");
        run_frame(32'h0300, 16, "r0300");
        reset_mid_frame();
        run_frame(32'h80FF, 16, "w80FF");
        check("w80FF reg0 4b", 64'(regs4[3:0]), 64'hF);
        run_frame(32'h0000, 16, "r0000");

        for (int t = 0; t < 30; t++) begin
            kind  = $urandom_range(0, 4);
            nbits = 16;
            bits  = $urandom;
            case (kind)
                0: bits = {16'h0, 1'b1, 7'($urandom_range(0, 7)), 8'($urandom)};
                1: bits = {16'h0, 1'b1, 7'($urandom_range(8, 127)), 8'($urandom)};
                2: bits = {16'h0, 1'b0, 7'($urandom_range(0, 9)), 8'($urandom)};
                3: nbits = $urandom_range(1, 15);
                default: nbits = $urandom_range(17, 20);
            endcase
            run_frame(bits, nbits, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
